ethernet_tx_arbiter: RTL and testbench
======================================

ETHERNET_TX_ARBITER -- requirements
Module: ethernet_tx_arbiter

Interface
REQ-001 SHALL have parameter data_width_p, default 32, downstream write-data width in bits.
REQ-002 SHALL have parameter eth_mtu_p, default 2048, max packet bytes; psize_w = $clog2(eth_mtu_p+1) = 12, paddr_w = $clog2(eth_mtu_p) = 11, size_w = `BSG_WIDTH(`BSG_SAFE_CLOG2(data_width_p/8)) = 2.
REQ-003 SHALL have parameter num_req_p, default 2, number of requesters, range 2..8.
REQ-004 SHALL have parameter timeout_p, default 4096, idle cycles before a grant is revoked; the counter is $clog2(timeout_p+1) bits wide.
REQ-005 clk_i  in  1  the only clock.
REQ-006 reset_i  in  1  asynchronous, active-high reset.
REQ-007 req_v_i  in  num_req_p  per-requester request for ownership of the TX buffer.
REQ-008 grant_o  out  num_req_p  one-hot owner indication; all zero when there is no owner.
REQ-009 req_packet_send_i  in  num_req_p  per-requester send strobe.
REQ-010 req_wsize_valid_i / req_wsize_i  in  num_req_p / num_req_p*psize_w  per-requester packet-size write.
REQ-011 req_wvalid_i / req_waddr_i / req_wdata_i / req_wdata_size_i  in  num_req_p / *paddr_w / *data_width_p / *size_w  per-requester buffer write.
REQ-012 packet_req_i  in  1  the sender's TX buffer is free.
REQ-013 packet_send_o, packet_wsize_valid_o, packet_wsize_o, packet_wvalid_o, packet_waddr_o, packet_wdata_o, packet_wdata_size_o  out  widths match the REQ-010/011 fields  write port to the sender.
REQ-014 timeout_o  out  num_req_p  sticky per-requester timeout flag.
REQ-015 timeout_clear_i  in  num_req_p  clears the matching timeout_o bits.

Function
REQ-016 The FSM SHALL have three states: IDLE, GRANT and RELEASE.
REQ-017 In IDLE, when packet_req_i=1 and req_v_i!=0, the FSM SHALL pick a winner round-robin (first asserted bit at or after rr_ptr, wrapping), register it, and enter GRANT; grant_o SHALL assert on the next cycle (1-cycle latency).
REQ-018 In IDLE with packet_req_i=0, the FSM SHALL issue no grant regardless of req_v_i.
REQ-019 In GRANT, the downstream write/send outputs SHALL be a zero-latency combinational mux of the owner's inputs.
REQ-020 In every state other than GRANT, all downstream valid and send outputs SHALL be 0 and data outputs SHALL be 0.
REQ-021 Inputs from non-owners SHALL be ignored, with no effect on state.
REQ-022 In GRANT, the owner's req_packet_send_i=1 SHALL produce packet_send_o=1 in the same cycle, then the FSM SHALL move to RELEASE.
REQ-023 In GRANT, owner req_v_i=0 without send (abort) SHALL move the FSM to RELEASE with no packet_send_o.
REQ-024 If send and req_v_i drop occur in the same cycle, the send SHALL be forwarded.
REQ-025 In GRANT, an idle counter SHALL increment on each cycle with no owner wvalid, wsize_valid or send, and SHALL clear to 0 on any such activity.
REQ-026 When the idle counter reaches timeout_p, the FSM SHALL enter RELEASE and set timeout_o[owner].
REQ-027 RELEASE SHALL last exactly 1 cycle with grant_o=0, then return to IDLE.
REQ-028 On entering RELEASE, rr_ptr SHALL become (owner+1) mod num_req_p, so the previous owner has lowest priority.
REQ-029 timeout_o set and timeout_clear_i in the same cycle SHALL leave the bit set (set wins).
REQ-030 The idle counter SHALL saturate, never wrapping.

Reset
REQ-031 During reset, the FSM SHALL be IDLE; grant_o, timeout_o, rr_ptr and the idle counter SHALL be 0; all downstream outputs SHALL be 0.
REQ-032 Reset asserted mid-GRANT SHALL drop grant_o and packet_send_o immediately (asynchronously); no partial send SHALL be issued after reset release.
REQ-033 After reset, requester 0 SHALL have first priority.

Verification
REQ-034 Reset, req_v_i=2'b11, packet_req_i=1 -> grant_o=2'b01 one cycle later; after req0 sends -> RELEASE, then grant_o=2'b10.
REQ-035 Requester 1 granted, writes waddr=5 data=32'hDEADBEEF while requester 0 writes waddr=7 -> downstream shows waddr=5 and 32'hDEADBEEF only, same cycle.
REQ-036 packet_req_i=0, req_v_i=2'b01 for 20 cycles -> grant_o stays 0; packet_req_i rises -> grant 1 cycle later.
REQ-037 timeout_p=8, owner idle -> at the 8th idle cycle the FSM enters RELEASE and timeout_o[owner]=1; timeout_clear_i pulse -> bit clears.
REQ-038 Owner asserts send and deasserts req_v_i in the same cycle -> packet_send_o=1 for exactly 1 cycle.
REQ-039 Reset pulse mid-GRANT -> grant_o=0 and all downstream valids 0 immediately; after release, requester 0 has priority.

Source files
------------

// File: rtl/ethernet_tx_arbiter.sv
// Round-robin arbiter granting one requester at a time ownership of a shared Ethernet TX buffer.
// Latency: grant one cycle after request while the sender is free; owner writes/sends pass through combinationally.
// Backpressure: arbitration stalls while packet_req_i=0; ownership is dropped on send, abort or idle timeout.
module ethernet_tx_arbiter #(
    parameter int data_width_p = 32,
    parameter int eth_mtu_p    = 2048,
    parameter int num_req_p    = 2,
    parameter int timeout_p    = 4096,
    localparam int psize_w     = $clog2(eth_mtu_p + 1),
    localparam int paddr_w     = $clog2(eth_mtu_p),
    localparam int bytes_lg_w  = ((data_width_p / 8) <= 1) ? 1 : $clog2(data_width_p / 8),
    localparam int size_w      = $clog2(bytes_lg_w + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,

    input  logic [num_req_p-1:0]              req_v_i,
    output logic [num_req_p-1:0]              grant_o,

    input  logic [num_req_p-1:0]              req_packet_send_i,
    input  logic [num_req_p-1:0]              req_wsize_valid_i,
    input  logic [num_req_p*psize_w-1:0]      req_wsize_i,
    input  logic [num_req_p-1:0]              req_wvalid_i,
    input  logic [num_req_p*paddr_w-1:0]      req_waddr_i,
    input  logic [num_req_p*data_width_p-1:0] req_wdata_i,
    input  logic [num_req_p*size_w-1:0]       req_wdata_size_i,

    input  logic                              packet_req_i,
    output logic                              packet_send_o,
    output logic                              packet_wsize_valid_o,
    output logic [psize_w-1:0]                packet_wsize_o,
    output logic                              packet_wvalid_o,
    output logic [paddr_w-1:0]                packet_waddr_o,
    output logic [data_width_p-1:0]           packet_wdata_o,
    output logic [size_w-1:0]                 packet_wdata_size_o,

    output logic [num_req_p-1:0]              timeout_o,
    input  logic [num_req_p-1:0]              timeout_clear_i
);

    localparam int idx_w = $clog2(num_req_p);
    localparam int cnt_w = $clog2(timeout_p + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e               r_state;
    logic [idx_w-1:0]     r_owner;
    logic [idx_w-1:0]     r_rr_ptr;
    logic [num_req_p-1:0] r_grant;
    logic [num_req_p-1:0] r_timeout;
    logic [cnt_w-1:0]     r_idle_cnt;

    logic                 w_found;
    logic [idx_w-1:0]     w_winner;
    logic [idx_w-1:0]     w_next_rr;
    logic                 w_active;
    logic                 w_own_v;
    logic                 w_own_send;
    logic                 w_own_wvalid;
    logic                 w_own_wsize_v;
    logic                 w_own_write;
    logic                 w_idle_hit;
    logic                 w_release;
    logic                 w_timed_out;
    logic [num_req_p-1:0] w_tmo_set;

    function automatic logic [num_req_p-1:0] onehot(input logic [idx_w-1:0] idx);
        logic [num_req_p-1:0] oh;
        for (int i = 0; i < num_req_p; i++) begin
            oh[i] = (i == int'(idx));
        end
        return oh;
    endfunction

    // Round-robin pick: first requester at or after r_rr_ptr, wrapping; lowest offset wins
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            int s;
            s = int'(r_rr_ptr) + k;
            if (s >= num_req_p) begin
                s = s - num_req_p;
            end
            if (req_v_i[s]) begin
                w_found  = 1'b1;
                w_winner = s[idx_w-1:0];
            end
        end
    end

    assign w_active      = (r_state == ST_GRANT);
    assign w_own_v       = req_v_i[r_owner];
    assign w_own_send    = req_packet_send_i[r_owner];
    assign w_own_wvalid  = req_wvalid_i[r_owner];
    assign w_own_wsize_v = req_wsize_valid_i[r_owner];
    assign w_own_write   = w_own_wvalid | w_own_wsize_v;

    // This idle cycle is the one that brings the counter up to timeout_p
    assign w_idle_hit    = (r_idle_cnt >= cnt_w'(timeout_p - 1));

    // A send or a dropped request ends ownership; a send always wins so it is never lost
    assign w_release     = w_active & (w_own_send | ~w_own_v);
    assign w_timed_out   = w_active & ~w_release & ~w_own_write & w_idle_hit;
    assign w_tmo_set     = w_timed_out ? onehot(r_owner) : '0;

    // Previous owner drops to lowest priority
    assign w_next_rr     = (r_owner == idx_w'(num_req_p - 1)) ? '0 : r_owner + 1'b1;

    // Downstream port: owner's inputs muxed through while in GRANT, otherwise held at zero
    always_comb begin
        packet_send_o        = 1'b0;
        packet_wsize_valid_o = 1'b0;
        packet_wsize_o       = '0;
        packet_wvalid_o      = 1'b0;
        packet_waddr_o       = '0;
        packet_wdata_o       = '0;
        packet_wdata_size_o  = '0;
        if (w_active) begin
            packet_send_o        = w_own_send;
            packet_wsize_valid_o = w_own_wsize_v;
            packet_wsize_o       = req_wsize_i[r_owner*psize_w +: psize_w];
            packet_wvalid_o      = w_own_wvalid;
            packet_waddr_o       = req_waddr_i[r_owner*paddr_w +: paddr_w];
            packet_wdata_o       = req_wdata_i[r_owner*data_width_p +: data_width_p];
            packet_wdata_size_o  = req_wdata_size_i[r_owner*size_w +: size_w];
        end
    end

    // Ownership FSM: arbitrate in IDLE, track owner activity in GRANT, one dead cycle in RELEASE
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_idle_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (packet_req_i && w_found) begin
                        r_owner    <= w_winner;
                        r_grant    <= onehot(w_winner);
                        r_idle_cnt <= '0;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_release || w_timed_out) begin
                        r_state  <= ST_RELEASE;
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_rr;
                    end
                    if (w_own_send || w_own_write) begin
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt != {cnt_w{1'b1}}) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Sticky timeout flags; a new timeout beats a simultaneous clear
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_timeout <= '0;
        end else begin
            r_timeout <= (r_timeout & ~timeout_clear_i) | w_tmo_set;
        end
    end

    assign grant_o   = r_grant;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// Testbench for ethernet_tx_arbiter: directed scenarios then randomized traffic against a reference model.
// Checks every cycle at the falling edge; model advances on the rising edge with the same inputs.
// Sender backpressure (packet_req_i) is randomized along with requester traffic.
module tb_ethernet_tx_arbiter;

    localparam int N   = 2;
    localparam int DW  = 32;
    localparam int MTU = 2048;
    localparam int TMO = 8;
    localparam int PS  = $clog2(MTU + 1);
    localparam int PA  = $clog2(MTU);
    localparam int SW  = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_v, grant, send_in, wsize_v_in, wvalid_in, tmo, tmo_clr;
    logic [N*PS-1:0] wsize_in;
    logic [N*PA-1:0] waddr_in;
    logic [N*DW-1:0] wdata_in;
    logic [N*SW-1:0] wdsz_in;
    logic            packet_req;
    logic            p_send, p_wsize_v, p_wvalid;
    logic [PS-1:0]   p_wsize;
    logic [PA-1:0]   p_waddr;
    logic [DW-1:0]   p_wdata;
    logic [SW-1:0]   p_wdsz;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int           m_owner;
    bit           m_rel;
    int           m_rr;
    int           m_idle;
    logic [N-1:0] m_tmo;

    ethernet_tx_arbiter #(
        .data_width_p(DW), .eth_mtu_p(MTU), .num_req_p(N), .timeout_p(TMO)
    ) dut (
        .clk_i(clk), .reset_i(rst),
        .req_v_i(req_v), .grant_o(grant),
        .req_packet_send_i(send_in),
        .req_wsize_valid_i(wsize_v_in), .req_wsize_i(wsize_in),
        .req_wvalid_i(wvalid_in), .req_waddr_i(waddr_in),
        .req_wdata_i(wdata_in), .req_wdata_size_i(wdsz_in),
        .packet_req_i(packet_req),
        .packet_send_o(p_send),
        .packet_wsize_valid_o(p_wsize_v), .packet_wsize_o(p_wsize),
        .packet_wvalid_o(p_wvalid), .packet_waddr_o(p_waddr),
        .packet_wdata_o(p_wdata), .packet_wdata_size_o(p_wdsz),
        .timeout_o(tmo), .timeout_clear_i(tmo_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_rel   = 1'b0;
        m_rr    = 0;
        m_idle  = 0;
        m_tmo   = '0;
    endtask

    // Expected outputs: owner's fields pass through, everything else is zero
    task automatic model_compare();
        logic [N-1:0]  e_grant;
        logic          e_send, e_wsv, e_wv;
        logic [PS-1:0] e_wsize;
        logic [PA-1:0] e_waddr;
        logic [DW-1:0] e_wdata;
        logic [SW-1:0] e_wdsz;
        int o;
        o = m_owner;
        e_grant = '0; e_send = 0; e_wsv = 0; e_wv = 0;
        e_wsize = '0; e_waddr = '0; e_wdata = '0; e_wdsz = '0;
        if (o >= 0) begin
            e_grant[o] = 1'b1;
            e_send  = send_in[o];
            e_wsv   = wsize_v_in[o];
            e_wsize = wsize_in[o*PS +: PS];
            e_wv    = wvalid_in[o];
            e_waddr = waddr_in[o*PA +: PA];
            e_wdata = wdata_in[o*DW +: DW];
            e_wdsz  = wdsz_in[o*SW +: SW];
        end
        chk("m_grant",  grant,     e_grant);
        chk("m_send",   p_send,    e_send);
        chk("m_wsv",    p_wsize_v, e_wsv);
        chk("m_wsize",  p_wsize,   e_wsize);
        chk("m_wvalid", p_wvalid,  e_wv);
        chk("m_waddr",  p_waddr,   e_waddr);
        chk("m_wdata",  p_wdata,   e_wdata);
        chk("m_wdsz",   p_wdsz,    e_wdsz);
        chk("m_tmo",    tmo,       m_tmo);
    endtask

    // Ownership rules applied to the inputs present at the rising edge
    task automatic model_step();
        logic [N-1:0] new_tmo;
        bit rel;
        int o;
        new_tmo = m_tmo & ~tmo_clr;
        rel = 1'b0;
        o = m_owner;
        if (m_rel) begin
            m_rel = 1'b0;
        end else if (o < 0) begin
            if (packet_req) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (req_v[c] && m_owner < 0) begin
                        m_owner = c;
                        m_idle  = 0;
                    end
                end
            end
        end else if (send_in[o] || !req_v[o]) begin
            rel = 1'b1;
        end else if (wvalid_in[o] || wsize_v_in[o]) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == TMO) begin
                new_tmo[o] = 1'b1;
                rel = 1'b1;
            end
        end
        if (rel) begin
            m_owner = -1;
            m_rel   = 1'b1;
            m_rr    = (o + 1) % N;
        end
        m_tmo = new_tmo;
    endtask

    task automatic cyc();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        req_v = '0; send_in = '0; wsize_v_in = '0; wvalid_in = '0; tmo_clr = '0;
        wsize_in = '0; waddr_in = '0; wdata_in = '0; wdsz_in = '0;
        packet_req = 1'b0;
    endtask

    task automatic rand_inputs(input int act_pct);
        for (int i = 0; i < N; i++) begin
            req_v[i]      = ($urandom_range(99) < 85);
            send_in[i]    = ($urandom_range(99) < 4);
            wvalid_in[i]  = ($urandom_range(99) < act_pct);
            wsize_v_in[i] = ($urandom_range(99) < act_pct / 2);
            tmo_clr[i]    = ($urandom_range(99) < 5);
            wsize_in[i*PS +: PS] = PS'($urandom);
            waddr_in[i*PA +: PA] = PA'($urandom);
            wdata_in[i*DW +: DW] = $urandom;
            wdsz_in[i*SW +: SW]  = SW'($urandom);
        end
        packet_req = ($urandom_range(99) < 70);
    endtask

    initial begin
        int act;
        rst = 1'b0;
        clear_inputs();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant",  grant,    2'b00);
        chk("rst_tmo",    tmo,      2'b00);
        chk("rst_send",   p_send,   1'b0);
        chk("rst_wvalid", p_wvalid, 1'b0);
        chk("rst_waddr",  p_waddr,  '0);
        chk("rst_wdata",  p_wdata,  '0);
        rst = 1'b0;
        model_reset();

        // Both request: requester 0 first, then requester 1 after release
        req_v = 2'b11; packet_req = 1'b1;
        cyc();
        send_in = 2'b01;
        #1 chk("rr_grant0", grant, 2'b01);
        chk("rr_send0", p_send, 1'b1);
        cyc();
        send_in = 2'b00;
        #1 chk("rel_grant", grant, 2'b00);
        chk("rel_send", p_send, 1'b0);
        cyc();
        #1 chk("idle_grant", grant, 2'b00);
        cyc();
        #1 chk("rr_grant1", grant, 2'b10);

        // Owner 1's write passes through, requester 0's write is ignored
        wvalid_in = 2'b11;
        waddr_in[0*PA +: PA] = PA'(7);
        waddr_in[1*PA +: PA] = PA'(5);
        wdata_in[0*DW +: DW] = 32'h12345678;
        wdata_in[1*DW +: DW] = 32'hDEADBEEF;
        #1 chk("mux_waddr", p_waddr, 11'd5);
        chk("mux_wdata", p_wdata, 32'hDEADBEEF);
        chk("mux_wvalid", p_wvalid, 1'b1);
        cyc();
        wvalid_in = 2'b00; req_v = 2'b00;
        cyc();
        cyc();

        // Sender busy: no grant however long the request is held
        packet_req = 1'b0; req_v = 2'b01;
        for (int i = 0; i < 20; i++) begin
            #1 chk("busy_grant", grant, 2'b00);
            cyc();
        end
        packet_req = 1'b1;
        #1 chk("free_grant_pre", grant, 2'b00);
        cyc();
        #1 chk("free_grant", grant, 2'b01);

        // Idle timeout: one write resets the counter, then 8 idle cycles
        wvalid_in = 2'b01;
        cyc();
        wvalid_in = 2'b00;
        for (int i = 0; i < TMO - 1; i++) begin
            #1 chk("tmo_hold_grant", grant, 2'b01);
            chk("tmo_hold_flag", tmo, 2'b00);
            cyc();
        end
        #1 chk("tmo_last_grant", grant, 2'b01);
        cyc();
        #1 chk("tmo_rel_grant", grant, 2'b00);
        chk("tmo_flag_set", tmo, 2'b01);
        req_v = 2'b00; tmo_clr = 2'b01;
        cyc();
        tmo_clr = 2'b00;
        #1 chk("tmo_flag_clr", tmo, 2'b00);

        // Send and request drop together: send forwarded for one cycle only
        req_v = 2'b01;
        cyc();
        #1 chk("sd_grant", grant, 2'b01);
        send_in = 2'b01; req_v = 2'b00;
        #1 chk("sd_send", p_send, 1'b1);
        cyc();
        send_in = 2'b00;
        #1 chk("sd_send_after", p_send, 1'b0);
        chk("sd_grant_after", grant, 2'b00);
        cyc();

        // Reset mid-grant: everything drops at once, requester 0 first afterwards
        req_v = 2'b11;
        cyc();
        #1 chk("mr_grant1", grant, 2'b10);
        wvalid_in = 2'b10; send_in = 2'b10;
        #1 chk("mr_wvalid", p_wvalid, 1'b1);
        rst = 1'b1;
        #1 chk("mr_rst_grant", grant, 2'b00);
        chk("mr_rst_wvalid", p_wvalid, 1'b0);
        chk("mr_rst_send", p_send, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wvalid_in = 2'b00; send_in = 2'b00;
        cyc();
        #1 chk("mr_grant0", grant, 2'b01);
        req_v = 2'b00;
        cyc();
        cyc();

        // Randomized traffic with varying activity levels
        act = 20;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) act = $urandom_range(0, 30);
            rand_inputs(act);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
